// File: rtl/stack_seq_pkg.sv
// stack_seq_pkg
//   Shared types and helpers for the stack sequencer.
//   - op_e      : request operation codes (6 and 7 are NOPs)
//   - state_e   : sequencer FSM states
//   - STACK_TOP_DEFAULT : empty-stack SP value / highest stack word address
//   - word_count(), is_push(), is_pop() : per-operation word bookkeeping
package stack_seq_pkg;

    localparam int STACK_TOP_DEFAULT = 2047;

    typedef enum logic [2:0] {
        OP_PUSH = 3'd0,
        OP_POP  = 3'd1,
        OP_CALL = 3'd2,
        OP_RET  = 3'd3,
        OP_INT  = 3'd4,
        OP_RTI  = 3'd5,
        OP_NOP6 = 3'd6,
        OP_NOP7 = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_RWAIT = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    function automatic logic [1:0] word_count(input op_e op);
        case (op)
            OP_PUSH, OP_POP: word_count = 2'd1;
            OP_CALL, OP_RET: word_count = 2'd2;
            OP_INT,  OP_RTI: word_count = 2'd3;
            default:         word_count = 2'd0;
        endcase
    endfunction

    function automatic logic is_push(input op_e op);
        is_push = (op == OP_PUSH) || (op == OP_CALL) || (op == OP_INT);
    endfunction

    function automatic logic is_pop(input op_e op);
        is_pop = (op == OP_POP) || (op == OP_RET) || (op == OP_RTI);
    endfunction

endpackage

// File: rtl/stack_limit_check.sv
// stack_limit_check
//   Combinational stack bounds check for the request being accepted.
//   Ports:
//     sp  in  AW : current stack pointer
//     op  in  op_e : requested operation
//     ovf out 1  : push of n words would need more than sp free words (M[0] reserved)
//     unf out 1  : pop of n words would move sp past STACK_TOP
module stack_limit_check
    import stack_seq_pkg::*;
#(
    parameter int AW        = 11,
    parameter int STACK_TOP = STACK_TOP_DEFAULT
) (
    input  logic [AW-1:0] sp,
    input  op_e           op,
    output logic          ovf,
    output logic          unf
);

    // One extra bit so sp + n cannot wrap before the compare.
    localparam logic [AW:0] TOP = (AW+1)'(STACK_TOP);

    logic [AW:0] n_ext;
    logic [AW:0] sp_ext;

    assign n_ext  = (AW+1)'(word_count(op));
    assign sp_ext = {1'b0, sp};
    assign ovf    = is_push(op) && (sp_ext < n_ext);
    assign unf    = is_pop(op) && ((sp_ext + n_ext) > TOP);

endmodule

// File: rtl/stack_sequencer.sv
// stack_sequencer
//   Sequences PUSH/POP/CALL/RET/INT/RTI stack traffic onto a shared 16-bit
//   data-memory port. Stack grows down; sp points at the next free word.
//   Optional feature macro: STACK_LIMIT_CHECK_EN (overflow/underflow detection;
//   when undefined sp simply wraps modulo 2^AW and exc_* stay 0).
//   Ports:
//     clk, reset                 : clock, async active-high reset
//     req_valid/req_ready        : request handshake (ready only in IDLE)
//     req_op, req_data, req_flags: operation, push operand / PC, INT flags
//     mem_req/we/addr/wdata      : memory port request, held until mem_gnt
//     mem_gnt, mem_rdata         : grant; read data valid the cycle after grant
//     rsp_valid/data/flags       : one-cycle completion with popped values
//     sp                         : current stack pointer (zero-extended)
//     busy                       : stall request, high outside IDLE
//     exc_ovf, exc_unf           : limit violation, valid with rsp_valid
//
//   state | meaning
//   IDLE  | waiting for a request, req_ready high
//   WRITE | pushing one word, mem_req held until granted
//   READ  | popping one word, mem_req held until granted
//   RWAIT | read data returns, captured here
//   DONE  | rsp_valid for one cycle
module stack_sequencer
    import stack_seq_pkg::*;
#(
    parameter int STACK_TOP = STACK_TOP_DEFAULT,
    parameter int AW        = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    req_op,
    input  logic [31:0]   req_data,
    input  logic [3:0]    req_flags,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_wdata,
    input  logic          mem_gnt,
    input  logic [15:0]   mem_rdata,
    output logic          rsp_valid,
    output logic [31:0]   rsp_data,
    output logic [3:0]    rsp_flags,
    output logic [31:0]   sp,
    output logic          busy,
    output logic          exc_ovf,
    output logic          exc_unf
);

    localparam logic [AW-1:0] SP_RESET = AW'(STACK_TOP);
    localparam logic [AW-1:0] SP_ONE   = AW'(1);

    state_e        state, state_next;
    op_e           op_in, op_q;
    logic [31:0]   data_q;
    logic [3:0]    flags_q;
    logic [1:0]    nwords, widx, slot;
    logic [AW-1:0] sp_q;
    logic [15:0]   w0, w1;
    logic [3:0]    flags_rd;
    logic          ovf_now, unf_now, ovf_q, unf_q;
    logic [15:0]   wdata_sel;

    assign op_in = op_e'(req_op);

`ifdef STACK_LIMIT_CHECK_EN
    stack_limit_check #(
        .AW        (AW),
        .STACK_TOP (STACK_TOP)
    ) u_limit (
        .sp  (sp_q),
        .op  (op_in),
        .ovf (ovf_now),
        .unf (unf_now)
    );
`else
    assign ovf_now = 1'b0;
    assign unf_now = 1'b0;
`endif

    // Push order is PC hi, PC lo, flags; widx counts words already done.
    always_comb begin
        wdata_sel = 16'h0000;
        if (op_q == OP_PUSH) begin
            wdata_sel = data_q[15:0];
        end else begin
            case (widx)
                2'd0:    wdata_sel = data_q[31:16];
                2'd1:    wdata_sel = data_q[15:0];
                default: wdata_sel = {12'h000, flags_q};
            endcase
        end
    end

    // Pops run in reverse, so the word just read lands in push slot n-widx.
    assign slot = nwords - widx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        busy       = 1'b1;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = sp_q;
        mem_wdata  = 16'h0000;
        rsp_valid  = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    if (ovf_now || unf_now)  state_next = S_DONE;
                    else if (is_push(op_in)) state_next = S_WRITE;
                    else if (is_pop(op_in))  state_next = S_READ;
                    else                     state_next = S_DONE;
                end
            end
            S_WRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_wdata = wdata_sel;
                if (mem_gnt && (widx == nwords - 2'd1)) state_next = S_DONE;
            end
            S_READ: begin
                mem_req  = 1'b1;
                mem_addr = sp_q + SP_ONE;
                if (mem_gnt) state_next = S_RWAIT;
            end
            S_RWAIT: begin
                state_next = (widx == nwords) ? S_DONE : S_READ;
            end
            S_DONE: begin
                rsp_valid  = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q     <= OP_PUSH;
            data_q   <= '0;
            flags_q  <= '0;
            nwords   <= '0;
            widx     <= '0;
            sp_q     <= SP_RESET;
            w0       <= '0;
            w1       <= '0;
            flags_rd <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q     <= op_in;
                        data_q   <= req_data;
                        flags_q  <= req_flags;
                        nwords   <= word_count(op_in);
                        widx     <= '0;
                        w0       <= '0;
                        w1       <= '0;
                        flags_rd <= '0;
                        ovf_q    <= ovf_now;
                        unf_q    <= unf_now;
                    end
                end
                S_WRITE: begin
                    if (mem_gnt) begin
                        sp_q <= sp_q - SP_ONE;
                        widx <= widx + 2'd1;
                    end
                end
                S_READ: begin
                    if (mem_gnt) begin
                        sp_q <= sp_q + SP_ONE;
                        widx <= widx + 2'd1;
                    end
                end
                S_RWAIT: begin
                    case (slot)
                        2'd0:    w0       <= mem_rdata;
                        2'd1:    w1       <= mem_rdata;
                        default: flags_rd <= mem_rdata[3:0];
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rsp_data  = 32'h0;
        rsp_flags = 4'h0;
        if (state == S_DONE) begin
            case (op_q)
                OP_POP: rsp_data = {16'h0000, w0};
                OP_RET: rsp_data = {w0, w1};
                OP_RTI: begin
                    rsp_data  = {w0, w1};
                    rsp_flags = flags_rd;
                end
                default: ;
            endcase
        end
    end

    assign sp      = {{(32-AW){1'b0}}, sp_q};
    assign exc_ovf = (state == S_DONE) && ovf_q;
    assign exc_unf = (state == S_DONE) && unf_q;

endmodule

// File: tb/tb_stack_sequencer.sv
module tb_stack_sequencer;

    localparam int AW  = 11;
    localparam int TOP = 2047;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } wr_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  flags;
        logic        ovf;
        logic        unf;
    } rsp_t;

    logic          clk;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_op;
    logic [31:0]   req_data;
    logic [3:0]    req_flags;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic          mem_gnt;
    logic [15:0]   mem_rdata;
    logic          rsp_valid;
    logic [31:0]   rsp_data;
    logic [3:0]    rsp_flags;
    logic [31:0]   sp;
    logic          busy;
    logic          exc_ovf;
    logic          exc_unf;

    logic [15:0] mem [0:TOP];
    wr_t  exp_wr[$];
    rsp_t exp_rsp[$];
    int checks = 0;
    int errors = 0;
    int wr_seen = 0;
    int rd_seen = 0;
    int rsp_seen = 0;
    int gnt_stall = 0;

    stack_sequencer #(.STACK_TOP(TOP), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_data  (req_data),
        .req_flags (req_flags),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_gnt   (mem_gnt),
        .mem_rdata (mem_rdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_flags (rsp_flags),
        .sp        (sp),
        .busy      (busy),
        .exc_ovf   (exc_ovf),
        .exc_unf   (exc_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Memory model and scoreboard: grant decided at negedge for the next posedge.
    initial begin
        int            stall_cnt;
        bit            rd_pend;
        logic [AW-1:0] rd_addr;
        wr_t           e;
        rsp_t          r;
        stall_cnt = 0;
        rd_pend   = 0;
        rd_addr   = '0;
        mem_gnt   = 1'b0;
        mem_rdata = 16'hDEAD;
        forever begin
            @(negedge clk);
            if (rd_pend) begin
                mem_rdata = mem[rd_addr];
                rd_pend   = 0;
            end else begin
                mem_rdata = 16'hDEAD;
            end
            mem_gnt = 1'b0;
            if (reset) begin
                stall_cnt = 0;
            end else if (mem_req === 1'b1) begin
                if (stall_cnt < gnt_stall) begin
                    stall_cnt++;
                end else begin
                    stall_cnt = 0;
                    mem_gnt   = 1'b1;
                    if (mem_we) begin
                        wr_seen++;
                        checks++;
                        if (exp_wr.size() == 0) begin
                            errors++;
                            $display("FAIL mem_write: unexpected write addr=%0d data=%h", mem_addr, mem_wdata);
                        end else begin
                            e = exp_wr.pop_front();
                            if ({mem_addr, mem_wdata} !== e) begin
                                errors++;
                                $display("FAIL mem_write: got addr=%0d data=%h, want addr=%0d data=%h",
                                         mem_addr, mem_wdata, e.addr, e.data);
                            end
                        end
                        mem[mem_addr] = mem_wdata;
                    end else begin
                        rd_seen++;
                        rd_pend = 1;
                        rd_addr = mem_addr;
                    end
                end
            end
            if (rsp_valid === 1'b1) begin
                rsp_seen++;
                checks++;
                if (exp_rsp.size() == 0) begin
                    errors++;
                    $display("FAIL rsp: unexpected response data=%h", rsp_data);
                end else begin
                    r = exp_rsp.pop_front();
                    if ({rsp_data, rsp_flags, exc_ovf, exc_unf} !== r) begin
                        errors++;
                        $display("FAIL rsp: got data=%h flags=%h ovf=%b unf=%b, want data=%h flags=%h ovf=%b unf=%b",
                                 rsp_data, rsp_flags, exc_ovf, exc_unf, r.data, r.flags, r.ovf, r.unf);
                    end
                end
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] data, input logic [3:0] flags);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_data  = data;
        req_flags = flags;
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_data  = 32'h0;
        req_flags = 4'h0;
    endtask

    // Returns in the cycle after DONE (back in IDLE).
    task automatic wait_rsp(input int start, output bit ok);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (rsp_seen != start) begin
                ok = 1;
                break;
            end
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({sp, req_ready, busy, mem_req, mem_we, rsp_valid, rsp_data, rsp_flags, exc_ovf, exc_unf} !==
            {32'(TOP), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got sp=%0d ready=%b busy=%b mem_req=%b rsp_valid=%b, want sp=%0d ready=1 others 0",
                     sp, req_ready, busy, mem_req, rsp_valid, TOP);
        end
        reset = 1'b0;
    endtask

    task automatic test_push();
        int start;
        bit ok;
        gnt_stall = 0;
        exp_wr.push_back({11'd2047, 16'h1234});
        exp_rsp.push_back({32'h0, 4'h0, 1'b0, 1'b0});
        start = rsp_seen;
        issue(3'd0, 32'h0000_1234, 4'h0);
        @(negedge clk);
        #1;
        wait_rsp(start, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL push_timeout: no response"); end
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL push_rsp_one_cycle: rsp_valid=%b ready=%b, want 0/1", rsp_valid, req_ready);
        end
        checks++;
        if (sp !== 32'd2046) begin errors++; $display("FAIL push_sp: got %0d want 2046", sp); end
    endtask

    task automatic test_pop();
        int start, rd0;
        bit ok;
        rd0 = rd_seen;
        exp_rsp.push_back({32'h0000_1234, 4'h0, 1'b0, 1'b0});
        start = rsp_seen;
        issue(3'd1, 32'h0, 4'h0);
        wait_rsp(start, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL pop_timeout: no response"); end
        checks++;
        if (sp !== 32'd2047 || rd_seen - rd0 != 1) begin
            errors++;
            $display("FAIL pop_sp: got sp=%0d reads=%0d, want sp=2047 reads=1", sp, rd_seen - rd0);
        end
    endtask

    task automatic test_call_ret();
        int start;
        bit ok;
        exp_wr.push_back({11'd2047, 16'h0001});
        exp_wr.push_back({11'd2046, 16'h0040});
        exp_rsp.push_back({32'h0, 4'h0, 1'b0, 1'b0});
        start = rsp_seen;
        issue(3'd2, 32'h0001_0040, 4'h0);
        wait_rsp(start, ok);
        checks++;
        if (!ok || sp !== 32'd2045) begin
            errors++;
            $display("FAIL call_sp: got sp=%0d ok=%b, want 2045", sp, ok);
        end
        exp_rsp.push_back({32'h0001_0040, 4'h0, 1'b0, 1'b0});
        start = rsp_seen;
        issue(3'd3, 32'h0, 4'h0);
        wait_rsp(start, ok);
        checks++;
        if (!ok || sp !== 32'd2047) begin
            errors++;
            $display("FAIL ret_sp: got sp=%0d ok=%b, want 2047", sp, ok);
        end
    endtask

    task automatic test_int_rti();
        int start;
        bit ok;
        exp_wr.push_back({11'd2047, 16'h0000});
        exp_wr.push_back({11'd2046, 16'h0020});
        exp_wr.push_back({11'd2045, 16'h000A});
        exp_rsp.push_back({32'h0, 4'h0, 1'b0, 1'b0});
        start = rsp_seen;
        issue(3'd4, 32'h0000_0020, 4'hA);
        wait_rsp(start, ok);
        checks++;
        if (!ok || sp !== 32'd2044) begin
            errors++;
            $display("FAIL int_sp: got sp=%0d ok=%b, want 2044", sp, ok);
        end
        exp_rsp.push_back({32'h0000_0020, 4'hA, 1'b0, 1'b0});
        start = rsp_seen;
        issue(3'd5, 32'h0, 4'h0);
        wait_rsp(start, ok);
        checks++;
        if (!ok || sp !== 32'd2047) begin
            errors++;
            $display("FAIL rti_sp: got sp=%0d ok=%b, want 2047", sp, ok);
        end
    endtask

    task automatic test_nop();
        int start, wr0, rd0;
        bit ok;
        wr0 = wr_seen;
        rd0 = rd_seen;
        exp_rsp.push_back({32'h0, 4'h0, 1'b0, 1'b0});
        start = rsp_seen;
        issue(3'd6, 32'hFFFF_FFFF, 4'hF);
        wait_rsp(start, ok);
        checks++;
        if (!ok || sp !== 32'd2047 || wr_seen != wr0 || rd_seen != rd0) begin
            errors++;
            $display("FAIL nop: got ok=%b sp=%0d mem_ops=%0d, want ok=1 sp=2047 mem_ops=0",
                     ok, sp, (wr_seen - wr0) + (rd_seen - rd0));
        end
    endtask

    task automatic test_stall();
        int start, wr0;
        bit ok;
        logic prev_req, prev_gnt;
        logic [AW-1:0] prev_addr;
        logic [15:0] prev_wdata;
        gnt_stall = 3;
        wr0 = wr_seen;
        exp_wr.push_back({11'd2047, 16'h1234});
        exp_wr.push_back({11'd2046, 16'h5678});
        exp_rsp.push_back({32'h0, 4'h0, 1'b0, 1'b0});
        start = rsp_seen;
        issue(3'd2, 32'h1234_5678, 4'h0);
        #1;
        ok = 0;
        prev_req = 1'b0;
        prev_gnt = 1'b0;
        prev_addr = '0;
        prev_wdata = '0;
        for (int i = 0; i < 100; i++) begin
            if (rsp_seen != start) begin ok = 1; break; end
            checks++;
            if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy: got %b want 1", busy); end
            if (prev_req && !prev_gnt) begin
                checks++;
                if (mem_req !== 1'b1 || mem_addr !== prev_addr || mem_wdata !== prev_wdata) begin
                    errors++;
                    $display("FAIL stall_stable: got req=%b addr=%0d data=%h, want req=1 addr=%0d data=%h",
                             mem_req, mem_addr, mem_wdata, prev_addr, prev_wdata);
                end
            end
            prev_req = mem_req;
            prev_gnt = mem_gnt;
            prev_addr = mem_addr;
            prev_wdata = mem_wdata;
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        #1;
        checks++;
        if (!ok || wr_seen - wr0 != 2 || sp !== 32'd2045) begin
            errors++;
            $display("FAIL stall_call: got ok=%b writes=%0d sp=%0d, want ok=1 writes=2 sp=2045", ok, wr_seen - wr0, sp);
        end
        exp_rsp.push_back({32'h1234_5678, 4'h0, 1'b0, 1'b0});
        start = rsp_seen;
        issue(3'd3, 32'h0, 4'h0);
        wait_rsp(start, ok);
        checks++;
        if (!ok || sp !== 32'd2047) begin
            errors++;
            $display("FAIL stall_ret: got ok=%b sp=%0d, want ok=1 sp=2047", ok, sp);
        end
        gnt_stall = 0;
    endtask

    task automatic test_underflow();
        int start, wr0, rd0;
        bit ok;
        wr0 = wr_seen;
        rd0 = rd_seen;
`ifdef STACK_LIMIT_CHECK_EN
        exp_rsp.push_back({32'h0, 4'h0, 1'b0, 1'b1});
        start = rsp_seen;
        issue(3'd1, 32'h0, 4'h0);
        wait_rsp(start, ok);
        checks++;
        if (!ok || sp !== 32'd2047 || wr_seen != wr0 || rd_seen != rd0) begin
            errors++;
            $display("FAIL underflow: got ok=%b sp=%0d mem_ops=%0d, want ok=1 sp=2047 mem_ops=0",
                     ok, sp, (wr_seen - wr0) + (rd_seen - rd0));
        end
`else
        exp_rsp.push_back({32'h0000_BEEF, 4'h0, 1'b0, 1'b0});
        start = rsp_seen;
        issue(3'd1, 32'h0, 4'h0);
        wait_rsp(start, ok);
        checks++;
        if (!ok || sp !== 32'd0 || rd_seen - rd0 != 1) begin
            errors++;
            $display("FAIL pop_wrap: got ok=%b sp=%0d reads=%0d, want ok=1 sp=0 reads=1", ok, sp, rd_seen - rd0);
        end
        exp_wr.push_back({11'd0, 16'h5555});
        exp_rsp.push_back({32'h0, 4'h0, 1'b0, 1'b0});
        start = rsp_seen;
        issue(3'd0, 32'h0000_5555, 4'h0);
        wait_rsp(start, ok);
        checks++;
        if (!ok || sp !== 32'd2047) begin
            errors++;
            $display("FAIL push_wrap: got ok=%b sp=%0d, want ok=1 sp=2047", ok, sp);
        end
`endif
    endtask

`ifdef STACK_LIMIT_CHECK_EN
    task automatic test_overflow();
        int start, wr0;
        bit ok;
        for (int i = 0; i < TOP; i++) begin
            exp_wr.push_back({11'(TOP - i), 16'(i)});
            exp_rsp.push_back({32'h0, 4'h0, 1'b0, 1'b0});
            start = rsp_seen;
            issue(3'd0, 32'(i), 4'h0);
            wait_rsp(start, ok);
            if (!ok) begin
                checks++;
                errors++;
                $display("FAIL fill_timeout: word %0d", i);
                break;
            end
        end
        checks++;
        if (sp !== 32'd0) begin errors++; $display("FAIL fill_sp: got %0d want 0", sp); end
        wr0 = wr_seen;
        exp_rsp.push_back({32'h0, 4'h0, 1'b1, 1'b0});
        start = rsp_seen;
        issue(3'd2, 32'hCAFE_F00D, 4'h0);
        wait_rsp(start, ok);
        checks++;
        if (!ok || sp !== 32'd0 || wr_seen != wr0) begin
            errors++;
            $display("FAIL overflow: got ok=%b sp=%0d writes=%0d, want ok=1 sp=0 writes=0", ok, sp, wr_seen - wr0);
        end
    endtask
`endif

    task automatic test_reset_mid();
        int wr0, start;
        bit ok;
        gnt_stall = 0;
        wr0 = wr_seen;
        start = rsp_seen;
        exp_wr.push_back({11'(sp), 16'h0000});
        issue(3'd4, 32'h0000_0077, 4'h3);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (wr_seen != wr0) begin ok = 1; break; end
            @(negedge clk);
        end
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (!ok || mem_req !== 1'b0 || sp !== 32'(TOP) || req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got ok=%b mem_req=%b sp=%0d ready=%b busy=%b, want ok=1 mem_req=0 sp=%0d ready=1 busy=0",
                     ok, mem_req, sp, req_ready, busy, TOP);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (wr_seen - wr0 != 1 || rsp_seen != start || exp_wr.size() != 0 || exp_rsp.size() != 0 || sp !== 32'(TOP)) begin
            errors++;
            $display("FAIL reset_mid_after: got writes=%0d rsps=%0d pend_wr=%0d pend_rsp=%0d sp=%0d, want 1/0/0/0/%0d",
                     wr_seen - wr0, rsp_seen - start, exp_wr.size(), exp_rsp.size(), sp, TOP);
        end
    endtask

    initial begin
        for (int i = 0; i <= TOP; i++) mem[i] = 16'h0000;
        mem[0] = 16'hBEEF;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_data  = 32'h0;
        req_flags = 4'h0;
        test_reset();
        test_push();
        test_pop();
        test_call_ret();
        test_int_rti();
        test_nop();
        test_stall();
        test_underflow();
`ifdef STACK_LIMIT_CHECK_EN
        test_overflow();
`endif
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
